dot_product_acc_pipe: RTL and testbench

Parametrised, fully pipelined unsigned dot-product engine with valid/ready handshake and multi-beat accumulation.
- Each accepted beat carries LANES element pairs. The block forms LANES products and reduces them through a registered binary adder tree.
- Tree sums are accumulated across beats until a beat flagged last, then one result is emitted.
- Sits in the compute datapath between operand buffers and the result sink. It is the generalised successor of the fixed 4-lane, 4-bit dot-product pipeline.

---
 rtl/dotp_pkg.sv | 31 +++
 rtl/dotp_adder_tree.sv | 83 ++++++++
 rtl/dot_product_acc_pipe.sv | 143 ++++++++++++++
 tb/tb_dot_product_acc_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dotp_pkg.sv
// ----------------------------------------------------------------------------
// dotp_pkg
// Shared width helpers for the dot-product pipeline.
//   clog2   : ceiling log2 for elaboration-time sizing
//   tree_w  : width of the adder-tree root sum (2*IN_W + clog2(LANES))
//   level_w : width of one adder-tree level (products are level 0)
// ----------------------------------------------------------------------------
package dotp_pkg;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res++;
         v = v >> 1;
      end
      return res;
   endfunction

   function automatic int tree_w(input int lanes, input int in_w);
      return 2 * in_w + clog2(lanes);
   endfunction

   // Each reduction level adds one bit of headroom for the pairwise carry.
   function automatic int level_w(input int in_w, input int level);
      return 2 * in_w + level;
   endfunction

endpackage

// File: rtl/dotp_adder_tree.sv
// ----------------------------------------------------------------------------
// dotp_adder_tree
// Registered binary reduction of LANES products, one register per level
// (clog2(LANES) levels). Valid and last travel alongside the data.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_en                global advance enable (stall when low)
//   i_valid, i_last     sideband for the incoming product vector
//   i_prod              LANES products, lane k = [k*2*IN_W +: 2*IN_W]
//   o_valid, o_last     sideband aligned with o_sum
//   o_sum               root sum, tree_w(LANES, IN_W) bits
// ----------------------------------------------------------------------------
module dotp_adder_tree
   import dotp_pkg::*;
#(
   parameter int LANES = 4,
   parameter int IN_W  = 4
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic                             i_en,
   input  logic                             i_valid,
   input  logic                             i_last,
   input  logic [LANES*2*IN_W-1:0]          i_prod,
   output logic                             o_valid,
   output logic                             o_last,
   output logic [tree_w(LANES, IN_W)-1:0]   o_sum
);

   localparam int LEVELS = clog2(LANES);
   localparam int PW     = level_w(IN_W, 0);

   logic [LEVELS-1:0] vld_q;
   logic [LEVELS-1:0] last_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld_q  <= '0;
         last_q <= '0;
      end else if (i_en) begin
         vld_q[0]  <= i_valid;
         last_q[0] <= i_last;
         for (int l = 1; l < LEVELS; l++) begin
            vld_q[l]  <= vld_q[l-1];
            last_q[l] <= last_q[l-1];
         end
      end
   end

   for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
      localparam int W = level_w(IN_W, l);
      localparam int N = LANES >> l;

      logic [W-2:0] in_q  [2*N];
      logic [W-1:0] sum_q [N];

      if (l == 1) begin : g_src
         for (genvar i = 0; i < 2*N; i++) begin : g_in
            assign in_q[i] = i_prod[i*PW +: PW];
         end
      end else begin : g_src
         for (genvar i = 0; i < 2*N; i++) begin : g_in
            assign in_q[i] = g_lvl[l-1].sum_q[i];
         end
      end

      always_ff @(posedge i_clk) begin
         // NOTE: the sum arrays are reset too, so a reset leaves no stale
         // partial sums anywhere in the pipe, not just cleared valid bits.
         if (i_rst) begin
            for (int i = 0; i < N; i++) sum_q[i] <= '0;
         end else if (i_en) begin
            for (int i = 0; i < N; i++)
               sum_q[i] <= {1'b0, in_q[2*i]} + {1'b0, in_q[2*i+1]};
         end
      end
   end

   assign o_sum   = g_lvl[LEVELS].sum_q[0];
   assign o_valid = vld_q[LEVELS-1];
   assign o_last  = last_q[LEVELS-1];

endmodule

// File: rtl/dot_product_acc_pipe.sv
// ----------------------------------------------------------------------------
// dot_product_acc_pipe
// Fully pipelined unsigned dot product with multi-beat accumulation.
// Stages: input reg -> product reg -> adder tree (clog2(LANES) regs) ->
// accumulate/output reg. Latency 3 + clog2(LANES) edges from acceptance.
// A single enable (en = !o_valid || i_ready) advances every stage.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid, o_ready    beat handshake; beat = i_a, i_b, i_last
//   i_a, i_b            LANES unsigned elements, lane k = [k*IN_W +: IN_W]
//   i_last              final beat of the current vector
//   o_valid, i_ready    result handshake
//   o_out               accumulated dot product
//   o_ovf               overflow flag, qualified by o_valid
// Build option: define DOTP_SAT_EN for a saturating accumulator with a
// sticky overflow flag; otherwise the sum wraps and o_ovf is 0.
// ----------------------------------------------------------------------------
module dot_product_acc_pipe
   import dotp_pkg::*;
#(
   parameter int LANES = 4,
   parameter int IN_W  = 4,
   parameter int OUT_W = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [LANES*IN_W-1:0]  i_a,
   input  logic [LANES*IN_W-1:0]  i_b,
   input  logic                   i_last,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [OUT_W-1:0]       o_out,
   output logic                   o_ovf
);

   localparam int PW = level_w(IN_W, 0);
   localparam int TW = tree_w(LANES, IN_W);

   logic                  en;
   logic [LANES*IN_W-1:0] a_q, b_q;
   logic                  s0_valid_q, s0_last_q;
   logic [LANES*PW-1:0]   prod_q;
   logic                  s1_valid_q, s1_last_q;
   logic                  t_valid, t_last;
   logic [TW-1:0]         t_sum;
   logic [OUT_W-1:0]      acc_q, acc_base, acc_next;
   logic                  first_q;

   // A held result blocks the whole pipe, so nothing can be overwritten.
   assign en      = !o_valid || i_ready;
   assign o_ready = en;

   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so each
      // stage reads the previous stage's value from before this edge.
      if (i_rst) begin
         a_q        <= '0;
         b_q        <= '0;
         s0_valid_q <= 1'b0;
         s0_last_q  <= 1'b0;
         prod_q     <= '0;
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
      end else if (en) begin
         a_q        <= i_a;
         b_q        <= i_b;
         s0_valid_q <= i_valid;
         s0_last_q  <= i_last;
         for (int k = 0; k < LANES; k++)
            prod_q[k*PW +: PW] <= PW'(a_q[k*IN_W +: IN_W]) * PW'(b_q[k*IN_W +: IN_W]);
         s1_valid_q <= s0_valid_q;
         s1_last_q  <= s0_last_q;
      end
   end

   dotp_adder_tree #(
      .LANES (LANES),
      .IN_W  (IN_W)
   ) u_tree (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (en),
      .i_valid (s1_valid_q),
      .i_last  (s1_last_q),
      .i_prod  (prod_q),
      .o_valid (t_valid),
      .o_last  (t_last),
      .o_sum   (t_sum)
   );

   // The first beat of a vector ignores whatever the accumulator holds.
   assign acc_base = first_q ? '0 : acc_q;

`ifdef DOTP_SAT_EN
   logic [OUT_W:0] acc_wide;
   logic           ovf_next;
   logic           sticky_q;

   // NOTE: every always_comb output is assigned on every path, so no latch.
   always_comb begin
      acc_wide = {1'b0, acc_base} + (OUT_W+1)'(t_sum);
      ovf_next = (!first_q && sticky_q) || acc_wide[OUT_W];
      acc_next = ovf_next ? '1 : acc_wide[OUT_W-1:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sticky_q <= 1'b0;
         o_ovf    <= 1'b0;
      end else if (en && t_valid) begin
         sticky_q <= ovf_next;
         if (t_last) o_ovf <= ovf_next;
      end
   end
`else
   assign acc_next = acc_base + OUT_W'(t_sum);
   assign o_ovf    = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         acc_q   <= '0;
         first_q <= 1'b1;
         o_valid <= 1'b0;
         o_out   <= '0;
      end else if (en) begin
         // Bubbles and consumed results drop o_valid; o_out simply holds.
         o_valid <= t_valid && t_last;
         if (t_valid) begin
            if (t_last) begin
               o_out   <= acc_next;
               first_q <= 1'b1;
            end else begin
               acc_q   <= acc_next;
               first_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_dot_product_acc_pipe.sv
// ----------------------------------------------------------------------------
// tb_dot_product_acc_pipe
// Two instances share one stimulus stream: OUT_W=16 and OUT_W=10 (the narrow
// one exercises overflow). A scoreboard computes every expected result from
// the total of lane products per vector; directed tables and sequences cover
// latency, stalls, reset and overflow.
// ----------------------------------------------------------------------------
module tb_dot_product_acc_pipe;

   localparam int LANES = 4;
   localparam int IN_W  = 4;
   localparam int VW    = LANES * IN_W;

   typedef struct {
      longint unsigned out;
      bit              ovf;
   } res_t;

   typedef struct {
      logic [VW-1:0]   a;
      logic [VW-1:0]   b;
      longint unsigned want;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst, in_valid, in_last, in_ready;
   logic [VW-1:0] in_a, in_b;
   logic          rdy16, vld16, ovf16;
   logic [15:0]   out16;
   logic          rdy10, vld10, ovf10;
   logic [9:0]    out10;

   res_t            exp16[$], exp10[$];
   res_t            mon_r;
   longint unsigned run_tot = 0;
   int              n_checks = 0, n_errors = 0, delivered = 0;
   bit              drv_done;

   always #5 clk = ~clk;

   dot_product_acc_pipe #(.LANES(LANES), .IN_W(IN_W), .OUT_W(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy16),
      .i_a(in_a), .i_b(in_b), .i_last(in_last), .o_valid(vld16),
      .i_ready(in_ready), .o_out(out16), .o_ovf(ovf16)
   );

   dot_product_acc_pipe #(.LANES(LANES), .IN_W(IN_W), .OUT_W(10)) dut10 (
      .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy10),
      .i_a(in_a), .i_b(in_b), .i_last(in_last), .o_valid(vld10),
      .i_ready(in_ready), .o_out(out10), .o_ovf(ovf10)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      n_checks++;
      if (act !== want) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, want);
      end
   endtask

   function automatic longint unsigned dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
      longint unsigned s = 0;
      for (int k = 0; k < LANES; k++)
         s += 64'(a[k*IN_W +: IN_W]) * 64'(b[k*IN_W +: IN_W]);
      return s;
   endfunction

   // Expected result of a whole vector from its exact (unbounded) total.
   function automatic res_t model_result(input longint unsigned tot, input int w);
      longint unsigned maxv = (64'd1 << w) - 1;
      res_t r;
`ifdef DOTP_SAT_EN
      r.ovf = (tot > maxv);
      r.out = r.ovf ? maxv : tot;
`else
      r.ovf = 1'b0;
      r.out = tot & maxv;
`endif
      return r;
   endfunction

   task automatic model_accept(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic last);
      run_tot += dot(a, b);
      if (last) begin
         exp16.push_back(model_result(run_tot, 16));
         exp10.push_back(model_result(run_tot, 10));
         run_tot = 0;
      end
   endtask

   // Scoreboard: a result presented while the sink is ready is consumed.
   always @(negedge clk) begin
      if (!rst && in_ready) begin
         if (vld16) begin
            if (exp16.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL spurious_out16: got %0d with no result outstanding", out16);
            end else begin
               mon_r = exp16.pop_front();
               check("sb_out16", out16, mon_r.out);
               check("sb_ovf16", ovf16, mon_r.ovf);
               delivered++;
            end
         end
         if (vld10) begin
            if (exp10.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL spurious_out10: got %0d with no result outstanding", out10);
            end else begin
               mon_r = exp10.pop_front();
               check("sb_out10", out10, mon_r.out);
               check("sb_ovf10", ovf10, mon_r.ovf);
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Call just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic last);
      bit done = 1'b0;
      in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
      for (int t = 0; t < 64 && !done; t++) begin
         @(negedge clk);
         if (rdy16) begin
            model_accept(a, b, last);
            done = 1'b1;
         end
         next_cycle();
      end
      in_valid = 1'b0;
      check("send_accepted", done, 1);
   endtask

   // Counts falling edges until o_valid; n is 5 for a result at edge k+4.
   task automatic wait_result(output int n);
      bit found = 1'b0;
      n = 0;
      for (int t = 1; t <= 40 && !found; t++) begin
         @(negedge clk);
         if (vld16) begin
            n = t;
            found = 1'b1;
         end
      end
      check("result_seen", found, 1);
   endtask

   task automatic wait_idle();
      bit empty = 1'b0;
      for (int t = 0; t < 300 && !empty; t++) begin
         @(negedge clk);
         empty = (exp16.size() == 0) && (exp10.size() == 0);
      end
      check("drained", empty, 1);
      next_cycle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vec_t tbl[6];
      int   n, cnt, d0;
      bit   run;

      tbl[0] = '{16'h4321, 16'h8765, 70};
      tbl[1] = '{16'hFFFF, 16'hFFFF, 900};
      tbl[2] = '{16'h0000, 16'h0000, 0};
      tbl[3] = '{16'h1111, 16'h2222, 8};
      tbl[4] = '{16'hF0F0, 16'h0F0F, 0};
      tbl[5] = '{16'h00FF, 16'h0F0F, 225};

      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_ready = 1'b1;
      in_a = '0; in_b = '0;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_o_valid", vld16, 0);
      check("rst_o_out", out16, 0);
      check("rst_o_ovf", ovf16, 0);
      check("rst_o_valid10", vld10, 0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check("rst_o_ready", rdy16, 1);
      next_cycle();

      // Single beat 1,2,3,4 x 5,6,7,8: latency and one-cycle pulse
      send(16'h4321, 16'h8765, 1'b1);
      wait_result(n);
      check("t1_latency", n, 5);
      check("t1_out", out16, 70);
      @(negedge clk);
      check("t1_pulse_len", vld16, 0);
      next_cycle();

      // Table of single-beat vectors
      for (int i = 0; i < 6; i++) begin
         send(tbl[i].a, tbl[i].b, 1'b1);
         wait_result(n);
         check($sformatf("tbl%0d_latency", i), n, 5);
         check($sformatf("tbl%0d_out", i), out16, tbl[i].want);
         check($sformatf("tbl%0d_out10", i), out10, tbl[i].want);
         next_cycle();
      end

      // Two-beat vector: 8 + 900, no intermediate result
      send(16'h1111, 16'h2222, 1'b0);
      send(16'hFFFF, 16'hFFFF, 1'b1);
      wait_result(n);
      check("t3_latency", n, 5);
      check("t3_out", out16, 908);
      wait_idle();

      // Eight back-to-back single-beat vectors
      d0 = delivered;
      fork
         begin
            for (int i = 0; i < 8; i++) send(VW'($urandom), VW'($urandom), 1'b1);
         end
         begin
            wait_result(n);
            cnt = 1;
            run = 1'b1;
            for (int t = 0; t < 20 && run; t++) begin
               @(negedge clk);
               if (vld16) cnt++;
               else run = 1'b0;
            end
            check("t4_consecutive", cnt, 8);
         end
      join
      wait_idle();
      check("t4_delivered", delivered - d0, 8);

      // Same stream with a 3-cycle sink stall in the middle
      d0 = delivered;
      fork
         begin
            for (int i = 0; i < 8; i++) send(VW'($urandom), VW'($urandom), 1'b1);
         end
         begin
            wait_result(n);
            next_cycle();
            in_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               check("t4_stall_valid", vld16, 1);
               check("t4_stall_ready", rdy16, 0);
               check("t4_stall_ready10", rdy10, 0);
               check("t4_stall_hold", out16, (exp16.size() > 0) ? exp16[0].out : 64'hFFFF_FFFF);
            end
            next_cycle();
            in_ready = 1'b1;
         end
      join
      wait_idle();
      check("t4s_delivered", delivered - d0, 8);

      // Reset in the middle of a vector discards the partial sum
      send(16'h1111, 16'h2222, 1'b0);
      rst = 1'b1;
      next_cycle();
      check("t5_rst_valid", vld16, 0);
      check("t5_rst_out", out16, 0);
      check("t5_rst_ovf", ovf16, 0);
      rst = 1'b0;
      run_tot = 0;
      exp16.delete();
      exp10.delete();
      @(negedge clk);
      check("t5_ready_after_rst", rdy16, 1);
      next_cycle();
      send(16'h4321, 16'h8765, 1'b1);
      wait_result(n);
      check("t5_out", out16, 70);
      next_cycle();

      // Overflow on the 10-bit instance: 900 + 900
      send(16'hFFFF, 16'hFFFF, 1'b0);
      send(16'hFFFF, 16'hFFFF, 1'b1);
      wait_result(n);
`ifdef DOTP_SAT_EN
      check("t6_out10", out10, 1023);
      check("t6_ovf10", ovf10, 1);
`else
      check("t6_out10", out10, 776);
      check("t6_ovf10", ovf10, 0);
`endif
      check("t6_out16", out16, 1800);
      check("t6_ovf16", ovf16, 0);
      next_cycle();
      send(16'h4321, 16'h8765, 1'b1);
      wait_result(n);
      check("t6_next_out10", out10, 70);
      check("t6_next_ovf10", ovf10, 0);
      wait_idle();

      // Random multi-beat vectors with bubbles and a random sink
      d0 = delivered;
      drv_done = 1'b0;
      fork
         begin
            for (int v = 0; v < 30; v++) begin
               int beats = $urandom_range(1, 4);
               for (int b = 0; b < beats; b++) begin
                  if ($urandom_range(0, 4) == 0) next_cycle();
                  send(VW'($urandom), VW'($urandom), b == beats - 1);
               end
            end
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               next_cycle();
               in_ready = ($urandom_range(0, 3) != 0);
            end
            in_ready = 1'b1;
         end
      join
      wait_idle();
      check("rand_delivered", delivered - d0, 30);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
